// File: rtl/cross_4k_wctrl.sv
// W-channel sequencer behind the 4KB AW splitter: queues split-piece
// lengths, regenerates WLAST per piece and flags master WLAST mismatches.
module cross_4k_wctrl #(
  parameter int W_ID   = 4,
  parameter int W_DATA = 32,
  parameter int W_STRB = W_DATA/8,
  parameter int W_LEN  = 8,
  parameter int DEPTH  = 4,
  parameter int W_PTR  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_valid,
  input  logic [W_LEN-1:0]  pc_len,
  input  logic              pc_last,
  output logic              pc_ready,
  input  logic [W_ID-1:0]   m_axi_wid,
  input  logic [W_DATA-1:0] m_axi_wdata,
  input  logic [W_STRB-1:0] m_axi_wstrb,
  input  logic              m_axi_wlast,
  input  logic              m_axi_wvalid,
  output logic              m_axi_wready,
  output logic [W_ID-1:0]   s_axi_wid,
  output logic [W_DATA-1:0] s_axi_wdata,
  output logic [W_STRB-1:0] s_axi_wstrb,
  output logic              s_axi_wlast,
  output logic              s_axi_wvalid,
  input  logic              s_axi_wready,
  output logic [W_PTR:0]    pc_level,
  output logic              wlast_err
);

  localparam logic [W_PTR:0] LVL_FULL = DEPTH[W_PTR:0];
  localparam logic [W_PTR:0] LVL_ONE  = {{W_PTR{1'b0}}, 1'b1};
  localparam logic [W_PTR-1:0] PTR_ONE = {{(W_PTR-1){1'b0}}, 1'b1};

  logic [W_LEN-1:0] r_q_len  [DEPTH];
  logic             r_q_last [DEPTH];
  logic [W_PTR-1:0] r_wr_ptr;
  logic [W_PTR-1:0] r_rd_ptr;
  logic [W_PTR:0]   r_level;
  logic [W_LEN-1:0] r_beat_cnt;
  logic             r_err;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_xfer;
  logic             w_wlast;
  logic [W_LEN-1:0] w_head_len;
  logic             w_head_last;
  logic             w_late;
  logic             w_early;

  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == LVL_FULL);
  assign w_head_len  = r_q_len[r_rd_ptr];
  assign w_head_last = r_q_last[r_rd_ptr];

  assign pc_ready = !rst & !w_full;
  assign w_push   = pc_valid & pc_ready;

  assign s_axi_wvalid = m_axi_wvalid & !w_empty;
  assign m_axi_wready = s_axi_wready & !w_empty;
  assign s_axi_wid    = m_axi_wid;
  assign s_axi_wdata  = m_axi_wdata;
  assign s_axi_wstrb  = m_axi_wstrb;

  assign w_xfer  = s_axi_wvalid & s_axi_wready;
  assign w_wlast = !w_empty & (r_beat_cnt == w_head_len);
  assign s_axi_wlast = w_wlast;
  assign w_pop   = w_xfer & w_wlast;

  assign w_late  = w_wlast & w_head_last & !m_axi_wlast;
  assign w_early = m_axi_wlast & !(w_wlast & w_head_last);

  // Storage needs no reset: entries are only read below r_level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_len[r_wr_ptr]  <= pc_len;
      r_q_last[r_wr_ptr] <= pc_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_xfer & (w_late | w_early);
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      if (w_pop)
        r_beat_cnt <= '0;
      else if (w_xfer)
        r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  assign pc_level  = r_level;
  assign wlast_err = r_err;

endmodule
